sha_header_feeder: RTL

Source-side driver for the SHA-256 round core. Accepts one 640-bit block header per handshake and produces the core's start strobe and the padded 32-bit message-word stream for both 512-bit blocks, aligned to the core's 128-cycle job cadence. It also flags the cycle in which the core's hash output is valid and tags it with the nonce that produced it. It sits between the work-distribution logic and the core.

---
 rtl/sha_header_feeder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sha_header_feeder.sv
// Source-side feeder for the SHA-256 round core: registers a 640-bit header, emits the padded
// two-block message stream on a 128-cycle job cadence, and tags each finished hash with its nonce.
// Optional SHA_FEEDER_NONCE_SWEEP_EN: runs sweep_len+1 back-to-back jobs with an incrementing nonce.
module sha_header_feeder #(
   parameter int CYCLESWIDTH = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [639:0] header,
`ifdef SHA_FEEDER_NONCE_SWEEP_EN
   input  logic [31:0]  sweep_len,
`endif
   input  logic         header_valid,
   output logic         header_ready,
   output logic         core_start,
   output logic [31:0]  M,
   output logic         busy,
   output logic         result_valid,
   output logic [31:0]  result_nonce
);

   typedef enum logic [2:0] {IDLE, BLK1, GAP1, BLK2, GAP2} state_t;

   state_t                 state_reg;
   state_t                 state_next;
   logic [CYCLESWIDTH-1:0] cnt_reg;
   logic [CYCLESWIDTH-1:0] cnt_inc;
   logic [607:0]           hdr_reg;
   logic [31:0]            nonce_reg;
   logic [31:0]            hdr_words [20];
   logic [31:0]            m_next;
   logic                   job_end;
   logic                   last_job;
   logic                   xfer;
   logic                   chain;

   // Words 0-18 come from the stored header; word 19 is the live nonce of the running job.
   genvar gi;
   generate
      for (gi = 0; gi < 19; gi++) begin : g_words
         assign hdr_words[gi] = hdr_reg[607-32*gi -: 32];
      end
   endgenerate
   assign hdr_words[19] = nonce_reg;

   assign cnt_inc = cnt_reg + CYCLESWIDTH'(1);
   assign job_end = (state_reg != IDLE) && (cnt_reg == '1);
   assign xfer    = header_valid && header_ready;

`ifdef SHA_FEEDER_NONCE_SWEEP_EN
   logic [31:0] sweep_left_reg;
   assign last_job = (sweep_left_reg == 32'd0);
`else
   assign last_job = 1'b1;
`endif
   assign chain = job_end && !last_job;

   always_comb begin
      state_next = GAP2;
      if (cnt_inc < CYCLESWIDTH'(16))
         state_next = BLK1;
      else if (cnt_inc < CYCLESWIDTH'(64))
         state_next = GAP1;
      else if (cnt_inc < CYCLESWIDTH'(80))
         state_next = BLK2;
   end

   // Padded stream: block 1 = words 0-15; block 2 = words 16-19, pad bit, zeros, 640-bit length.
   always_comb begin
      m_next = 32'd0;
      if (cnt_inc < CYCLESWIDTH'(16))
         m_next = hdr_words[{1'b0, cnt_inc[3:0]}];
      else if (cnt_inc >= CYCLESWIDTH'(64) && cnt_inc < CYCLESWIDTH'(68))
         m_next = hdr_words[{3'b100, cnt_inc[1:0]}];
      else if (cnt_inc == CYCLESWIDTH'(68))
         m_next = 32'h8000_0000;
      else if (cnt_inc == CYCLESWIDTH'(79))
         m_next = 32'h0000_0280;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         hdr_reg      <= '0;
         nonce_reg    <= 32'd0;
         header_ready <= 1'b0;
         core_start   <= 1'b0;
         M            <= 32'd0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result_nonce <= 32'd0;
`ifdef SHA_FEEDER_NONCE_SWEEP_EN
         sweep_left_reg <= 32'd0;
`endif
      end else begin
         result_valid <= job_end;
         if (job_end)
            result_nonce <= nonce_reg;

         if (xfer || chain) begin
            state_reg    <= BLK1;
            cnt_reg      <= '0;
            core_start   <= 1'b1;
            busy         <= 1'b1;
            header_ready <= 1'b0;
            if (xfer) begin
               hdr_reg   <= header[639:32];
               nonce_reg <= header[31:0];
               M         <= header[639:608];
`ifdef SHA_FEEDER_NONCE_SWEEP_EN
               sweep_left_reg <= sweep_len;
`endif
            end else begin
               nonce_reg <= nonce_reg + 32'd1;
               M         <= hdr_words[0];
`ifdef SHA_FEEDER_NONCE_SWEEP_EN
               sweep_left_reg <= sweep_left_reg - 32'd1;
`endif
            end
         end else if (state_reg == IDLE || job_end) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            M            <= 32'd0;
            header_ready <= 1'b1;
         end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_inc;
            core_start   <= 1'b0;
            busy         <= 1'b1;
            M            <= m_next;
            // Only the final job of a sweep opens the handshake on its last cycle.
            header_ready <= (cnt_inc == '1) && last_job;
         end
      end
   end

endmodule
